booth_mult_ctrl: RTL
====================

BOOTH_MULT_CTRL -- requirements
Module: booth_mult_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-004 SHALL have port multiplicand, input, 32 bits: operand M; captured when start is accepted.
REQ-005 SHALL have port multiplier, input, 32 bits: operand Q; captured when start is accepted.
REQ-006 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-007 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-008 SHALL have port product, output, 64 bits: result register, held until the next accepted start or reset.
REQ-009 SHALL have port sign_mode, input, 1 bit, present only with MULT_UNSIGNED_EN: 1 = signed, 0 = unsigned; captured with the operands.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-011 SHALL go IDLE->RUN on a clock edge with start=1 and capture the operands, the step counter (cleared to 0), A=0 and q_m1=0 on that edge.
REQ-012 SHALL, in each RUN cycle, examine {Q[0],q_m1}: 01 -> A=A+M; 10 -> A=A-M (add ~M with carry-in 1); 00/11 -> A unchanged.
REQ-013 SHALL then arithmetic-shift {A,Q,q_m1} right by one bit in the same cycle.
REQ-014 SHALL hold A as 33 bits, with M extended to 33 bits, so that M = -2^31 does not overflow.
REQ-015 SHALL run N RUN cycles, then go RUN->DONE; N=32 in signed mode.
REQ-016 SHALL go DONE->IDLE unconditionally after one cycle; done=1 only in DONE; busy=1 only in RUN.
REQ-017 SHALL load product on the RUN->DONE edge with the exact 64-bit result {A,Q} low 64 bits; signed mode: signed(M) x signed(Q).
REQ-018 SHALL keep product stable outside that load edge; it is valid from the start of DONE.
REQ-019 SHALL ignore start in RUN and DONE; operands changing during RUN SHALL NOT affect the result.
REQ-020 SHALL give this latency: start accepted at edge E0 -> busy high after E0; done high for one cycle after E(N); busy low after E(N).
REQ-021 SHALL reach IDLE after E(N+1), where start=1 is accepted; back-to-back issue interval is N+2 cycles.

Reset
REQ-022 SHALL, on rst=1, take immediate effect regardless of clk: state=IDLE, counter=0, A=0, Q=0, q_m1=0, product=0, busy=0, done=0.
REQ-023 SHALL, on reset mid-RUN or in DONE, abort the operation with no done pulse; product reads 0.
REQ-024 SHALL accept start on the first clock edge after rst deasserts.

Configuration
REQ-025 SHALL use macro MULT_UNSIGNED_EN.
REQ-026 SHALL, when MULT_UNSIGNED_EN is defined, add port sign_mode.
REQ-027 SHALL, with sign_mode=0: zero-extend M and Q to 33 bits, use N=33, and produce product = unsigned(M) x unsigned(Q).
REQ-028 SHALL, with sign_mode=1: sign-extend and use N=32.
REQ-029 SHALL, when MULT_UNSIGNED_EN is undefined, omit sign_mode and always operate signed with N=32.

Verification
REQ-030 SHALL cover: M=3, Q=5, start at E0 -> done only after E32, product=64'h0000_0000_0000_000F, busy high E0..E32.
REQ-031 SHALL cover: M=32'hFFFF_FFFD (-3), Q=7 -> product=64'hFFFF_FFFF_FFFF_FFEB (-21).
REQ-032 SHALL cover: M=Q=32'h8000_0000 -> product=64'h4000_0000_0000_0000; also M=32'h8000_0000, Q=32'hFFFF_FFFF -> product=64'h0000_0000_8000_0000.
REQ-033 SHALL cover: start held high continuously with new operands pulsed mid-RUN -> operands ignored, first result unchanged, second start accepted after E33, done spacing 34 cycles.
REQ-034 SHALL cover: rst pulsed at E10 of RUN -> busy=0, done never pulses, product=0; next start completes normally.
REQ-035 SHALL cover, with MULT_UNSIGNED_EN: sign_mode=0, M=Q=32'hFFFF_FFFF -> done after E33, product=64'hFFFF_FFFE_0000_0001; sign_mode=1 same operands -> product=1 after E32.

Source files
------------

// File: rtl/booth_mult_ctrl.sv
// Radix-2 Booth sequential multiplier, 32x32 -> 64, one Booth step per RUN cycle.
// Optional unsigned mode (sign_mode port, 33 steps) enabled by `define MULT_UNSIGNED_EN.
module booth_mult_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
`ifdef MULT_UNSIGNED_EN
    input  logic        sign_mode,
`endif
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [32:0] acc;
    logic [32:0] mcand;
    logic [32:0] q;
    logic        q_m1;
    logic        sgn_in;
    logic        sgn_q;

`ifdef MULT_UNSIGNED_EN
    assign sgn_in = sign_mode;
`else
    assign sgn_in = 1'b1;
    assign sgn_q  = 1'b1;
`endif

    logic [33:0] sum;
    logic [32:0] acc_nx;
    logic [32:0] q_nx;
    logic [63:0] prod_nx;
    logic [5:0]  last;

    // Sum is one bit wider than A so the shifted result is exact even for M = -2^31.
    always_comb begin
        case ({q[0], q_m1})
            2'b01:   sum = {acc[32], acc} + {mcand[32], mcand};
            2'b10:   sum = {acc[32], acc} + ~{mcand[32], mcand} + 34'd1;
            default: sum = {acc[32], acc};
        endcase
        acc_nx = sum[33:1];
        q_nx   = {sum[0], q[32:1]};
        // Signed: 32 steps leave the unexamined sign-extension bit in q_nx[0].
        prod_nx = sgn_q ? {acc_nx[31:0], q_nx[32:1]} : {acc_nx[30:0], q_nx};
        last    = sgn_q ? 6'd31 : 6'd32;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef MULT_UNSIGNED_EN
            sgn_q   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        acc   <= '0;
                        q_m1  <= 1'b0;
                        mcand <= {sgn_in & multiplicand[31], multiplicand};
                        q     <= {sgn_in & multiplier[31], multiplier};
`ifdef MULT_UNSIGNED_EN
                        sgn_q <= sign_mode;
`endif
                    end
                end
                RUN: begin
                    acc  <= acc_nx;
                    q    <= q_nx;
                    q_m1 <= q[0];
                    cnt  <= cnt + 6'd1;
                    if (cnt == last) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= prod_nx;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
